rle_decoder: RTL

//  Run-length decoder for the JPEG datapath; inverse of the 8-lane RLE encoder.
//  - Consumes 12-bit {run[3:0], value[7:0]} symbols and expands each 64-coefficient zig-zag block.
//  - Emits 64-bit words of 8 coefficients, 8 words per block, toward the de-zigzag/IDCT side.
//  - Valid/ready handshakes on both sides.

---
 rtl/jpeg_rle_pkg.sv | 34 +++
 rtl/rle_lane_packer.sv | 62 ++++++
 rtl/rle_decoder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/jpeg_rle_pkg.sv
// Shared JPEG run-length constants, symbol codes and FSM state encoding.
// Used by both the RLE encoder and decoder so the two sides agree on the format.
package jpeg_rle_pkg;

    localparam int COEF_W    = 8;
    localparam int RUN_W     = 4;
    localparam int LANES     = 8;
    localparam int BLK_COEFS = 64;

    localparam int SYM_W  = RUN_W + COEF_W;
    localparam int WORD_W = LANES * COEF_W;
    localparam int IDX_W  = $clog2(BLK_COEFS);
    localparam int LANE_W = $clog2(LANES);

    localparam logic [SYM_W-1:0]  SYM_EOB   = 12'h000;
    localparam logic [SYM_W-1:0]  SYM_ZRL   = 12'hF00;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BLK_COEFS - 1);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);

    typedef enum logic [1:0] {
        S_SYM = 2'd0,
        S_RUN = 2'd1,
        S_EOB = 2'd2
    } rle_state_t;

    // True when a run starting at idx would spill past the last coefficient of the block.
    function automatic logic run_overflows(input logic [IDX_W-1:0] idx,
                                           input logic [RUN_W-1:0] run);
        logic [IDX_W:0] sum;
        sum = {1'b0, idx} + {{(IDX_W + 1 - RUN_W){1'b0}}, run};
        return sum > {1'b0, LAST_IDX};
    endfunction

endpackage

// File: rtl/rle_lane_packer.sv
// Packs one coefficient per emit into an 8-lane word; the word registers when lane 7 is written.
// Latency: 8 emits per word. Backpressure: can_emit drops only when lane 7 is next and the held word is not taken.
module rle_lane_packer
    import jpeg_rle_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              emit,
    input  logic [COEF_W-1:0] coef,
    input  logic              blk_end,
    input  logic              out_ready,
    output logic              can_emit,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last
);

    logic [LANE_W-1:0]             lane_ptr;
    logic [COEF_W-1:0]             lane_buf [LANES-1];
    logic [(LANES-1)*COEF_W-1:0]   packed_lanes;
    logic                          word_load;

    assign word_load = emit && (lane_ptr == LANE_LAST);
    assign can_emit  = !out_valid || out_ready || (lane_ptr != LANE_LAST);

    // Lane 0 holds the lowest coefficient index and lands in the top byte.
    always_comb begin
        packed_lanes = '0;
        for (int i = 0; i < LANES - 1; i++) begin
            packed_lanes[(LANES-2-i)*COEF_W +: COEF_W] = lane_buf[i];
        end
    end

    always_ff @(posedge clk) begin
        if (emit && !word_load) begin
            lane_buf[lane_ptr] <= coef;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lane_ptr  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (word_load) begin
            lane_ptr  <= '0;
            out_data  <= {packed_lanes, coef};
            out_valid <= 1'b1;
            out_last  <= blk_end;
        end else begin
            if (emit) begin
                lane_ptr <= lane_ptr + 1'b1;
            end
            if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rle_decoder.sv
// JPEG run-length decoder: expands {run,value} symbols into 64-coef blocks, 8 coefs per output word.
// Latency: 8 emit cycles to first word, 1 coef/clk; sym_ready falls when the packer cannot take a coefficient.
module rle_decoder
    import jpeg_rle_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [SYM_W-1:0]  sym_in,
    input  logic              sym_valid,
    output logic              sym_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              blk_err
);

    rle_state_t        state;
    logic [IDX_W-1:0]  coef_idx;
    logic [RUN_W-1:0]  run_cnt;
    logic [COEF_W-1:0] val_q;

    logic [RUN_W-1:0]  sym_run;
    logic [COEF_W-1:0] sym_val;
    logic              accept;
    logic              overflow;
    logic              can_emit;
    logic              emit;
    logic [COEF_W-1:0] emit_coef;

    assign sym_run   = sym_in[SYM_W-1:COEF_W];
    assign sym_val   = sym_in[COEF_W-1:0];
    assign overflow  = run_overflows(coef_idx, sym_run);
    assign sym_ready = reset && (state == S_SYM) && can_emit;
    assign accept    = sym_valid && sym_ready;

    // EOB and literal DC zero both carry run 0 / value 0, so they share the plain-literal path here.
    always_comb begin
        emit      = 1'b0;
        emit_coef = '0;
        case (state)
            S_SYM: begin
                emit      = accept && !overflow;
                emit_coef = (sym_run == '0) ? sym_val : '0;
            end
            S_RUN: begin
                emit      = can_emit;
                emit_coef = (run_cnt == '0) ? val_q : '0;
            end
            S_EOB: begin
                emit      = can_emit;
                emit_coef = '0;
            end
            default: begin
                emit      = 1'b0;
                emit_coef = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_SYM;
            coef_idx <= '0;
            run_cnt  <= '0;
            val_q    <= '0;
            blk_err  <= 1'b0;
        end else begin
            blk_err <= 1'b0;
            if (emit) begin
                coef_idx <= coef_idx + 1'b1;
            end
            case (state)
                S_SYM: begin
                    if (accept) begin
                        if (sym_in == SYM_EOB && coef_idx != '0) begin
                            if (coef_idx != LAST_IDX) begin
                                state <= S_EOB;
                            end
                        end else if (overflow) begin
                            blk_err <= 1'b1;
                        end else if (sym_run != '0) begin
                            run_cnt <= sym_run - 1'b1;
                            val_q   <= sym_val;
                            state   <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (can_emit) begin
                        if (run_cnt != '0) begin
                            run_cnt <= run_cnt - 1'b1;
                        end else begin
                            state <= S_SYM;
                        end
                    end
                end
                S_EOB: begin
                    if (can_emit && coef_idx == LAST_IDX) begin
                        state <= S_SYM;
                    end
                end
                default: state <= S_SYM;
            endcase
        end
    end

    rle_lane_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .emit      (emit),
        .coef      (emit_coef),
        .blk_end   (coef_idx == LAST_IDX),
        .out_ready (out_ready),
        .can_emit  (can_emit),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last)
    );

endmodule
